krv_dmem_responder: RTL

- Data-memory and IO responder for the KRV-32 core: the target end of the CPU load/store interface.
- Decodes byte addresses starting at BASE_ADDR (2000) and performs big-endian byte/half/word reads and writes with a valid/ready request handshake and a fixed wait-state response.
- Drives the 6-bit LED port from the byte at BASE_ADDR+3.
- Sits between the core's load/store state and the board IO.

---
 rtl/krv_pkg.sv | 29 ++
 rtl/krv_load_extend.sv | 22 ++
 rtl/krv_dmem_responder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/krv_pkg.sv
// Shared KRV-32 definitions: load/store funct3 codes, data-memory map and
// the state encoding for the data-memory responder.
package krv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned DATA_OFFSET = 2000;
  localparam int unsigned LED_OFFSET  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } dmem_state_e;

  // Access size in bytes; only meaningful for legal funct3 codes.
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/krv_load_extend.sv
// Selects the byte/half at the top of a big-endian read word and applies
// sign or zero extension according to the load funct3.
module krv_load_extend
  import krv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  always_comb begin
    data = word;
    case (funct3)
      F3_B:    data = {{24{word[31]}}, word[31:24]};
      F3_BU:   data = {24'h000000, word[31:24]};
      F3_H:    data = {{16{word[31]}}, word[31:16]};
      F3_HU:   data = {16'h0000, word[31:16]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/krv_dmem_responder.sv
// Data-memory / LED responder for the KRV-32 load/store port: big-endian
// byte/half/word access with a fixed number of wait states per request.
module krv_dmem_responder
  import krv_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DATA_OFFSET,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  leds
);

  localparam int unsigned AW = $clog2(DEPTH);

  dmem_state_e state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        we_q;
  logic [31:0] off_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [7:0]  led_q;
  logic [7:0]  mem_q [DEPTH];

  logic             in_idle, do_access;
  logic             acc_we, acc_err, f3_ok, misaligned, out_of_range;
  logic [31:0]      acc_off, acc_wdata, wshift, rd_word, ext_data;
  logic [2:0]       acc_f3, size;
  logic [AW-1:0]    acc_idx;
  logic [DEPTH-1:0] wr_en;
  logic [7:0]       wr_byte [DEPTH];

  // With zero wait states the access happens on the accept edge, so the
  // live request is used instead of the captured copy.
  assign in_idle   = (state_q == StIdle);
  assign acc_we    = in_idle ? req_we : we_q;
  assign acc_off   = in_idle ? (req_addr - 32'(BASE_ADDR)) : off_q;
  assign acc_f3    = in_idle ? req_funct3 : f3_q;
  assign acc_wdata = in_idle ? req_wdata : wdata_q;
  assign acc_idx   = acc_off[AW-1:0];

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    req_ready = 1'b0;
    case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wait_d  = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? StResp : StAccess;
        end
      end
      StAccess: begin
        wait_d = wait_q - 4'd1;
        if (wait_q <= 4'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign do_access = rst && (state_q != StResp) && (state_d == StResp);

  assign size         = f3_size(acc_f3);
  assign f3_ok        = (acc_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) &&
                        !(acc_we && acc_f3[2]);
  assign misaligned   = ((size == 3'd2) && acc_off[0]) ||
                        ((size == 3'd4) && (acc_off[1:0] != 2'b00));
  // Written as off > DEPTH - n so large offsets cannot wrap past the limit.
  assign out_of_range = acc_off > (32'(DEPTH) - 32'(size));
  assign acc_err      = !f3_ok || misaligned || out_of_range;

  // Left-justify store data so byte k of wshift lands at mem[off+k].
  assign wshift = (size == 3'd1) ? {acc_wdata[7:0], 24'h000000} :
                  (size == 3'd2) ? {acc_wdata[15:0], 16'h0000} : acc_wdata;

  always_comb begin : p_mem_comb
    logic [AW-1:0] idx;
    idx     = '0;
    rd_word = '0;
    wr_en   = '0;
    for (int i = 0; i < DEPTH; i++) wr_byte[i] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      idx = acc_idx + AW'(k);
      rd_word[31-8*k -: 8] = (idx == AW'(LED_OFFSET)) ? led_q : mem_q[idx];
      if (do_access && acc_we && !acc_err && (k < int'(size))) begin
        wr_en[idx]   = 1'b1;
        wr_byte[idx] = wshift[31-8*k -: 8];
      end
    end
  end

  krv_load_extend u_load_extend (
    .word   (rd_word),
    .funct3 (acc_f3),
    .data   (ext_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      wait_q  <= 4'd0;
      we_q    <= 1'b0;
      off_q   <= 32'd0;
      f3_q    <= 3'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      led_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (in_idle && req_valid) begin
        we_q    <= req_we;
        off_q   <= req_addr - 32'(BASE_ADDR);
        f3_q    <= req_funct3;
        wdata_q <= req_wdata;
      end
      if (do_access) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || acc_we) ? 32'd0 : ext_data;
      end
      if (wr_en[LED_OFFSET]) led_q <= wr_byte[LED_OFFSET];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i] && (i != int'(LED_OFFSET))) mem_q[i] <= wr_byte[i];
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
  assign rsp_err   = rsp_valid && err_q;
  assign leds      = ~led_q[5:0];

endmodule
